// File: rtl/zaxdma_pkg.sv
// Shared definitions for the zaxdma scheduler: FSM state encoding and a
// helper for locating per-channel fields inside packed descriptor buses.
package zaxdma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

  // LSB position of channel ch's field in a bus of width-bit fields
  function automatic int unsigned field_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/zaxdma_rrarb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module zaxdma_rrarb #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] gnt,
  output logic                   vld
);

  localparam int unsigned CHW = $clog2(NCH);
  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

  logic [NCH-1:0] win;
  logic [CHW-1:0] off;
  logic [CHW:0]   sum;

  // Rotate so ptr sits at bit 0, then take the lowest set bit
  always_comb begin
    win = NCH'({req, req} >> ptr);
    vld = 1'b0;
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (win[i]) begin
        vld = 1'b1;
        off = CHW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    gnt = (sum >= NCH_W) ? CHW'(sum - NCH_W) : CHW'(sum);
  end

endmodule

// File: rtl/zaxdma_sched.sv
// Round-robin scheduler sharing one AXI DMA engine between NCH requesters.
// Optional watchdog abort on a stuck engine: define ZAXDMA_SCHED_TIMEOUT_EN.
module zaxdma_sched
  import zaxdma_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned ADDRESS_WIDTH = 30,
  parameter int unsigned LGDMALENGTH   = 30,
  parameter int unsigned LGTIMEOUT     = 20
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [NCH-1:0]                 i_ch_req,
  input  logic [NCH*ADDRESS_WIDTH-1:0]   i_ch_src,
  input  logic [NCH*ADDRESS_WIDTH-1:0]   i_ch_dst,
  input  logic [NCH*LGDMALENGTH-1:0]     i_ch_len,
  input  logic [NCH-1:0]                 i_ch_abort,
  output logic [NCH-1:0]                 o_ch_ack,
  output logic [NCH-1:0]                 o_ch_done,
  output logic [NCH-1:0]                 o_ch_err,
  output logic                           o_busy,
  output logic [$clog2(NCH)-1:0]         o_active_ch,
  output logic                           o_dma_request,
  output logic                           o_dma_abort,
  input  logic                           i_dma_busy,
  input  logic                           i_dma_err,
  output logic [ADDRESS_WIDTH-1:0]       o_src_addr,
  output logic [ADDRESS_WIDTH-1:0]       o_dst_addr,
  output logic [LGDMALENGTH-1:0]         o_length
);

  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned AW  = ADDRESS_WIDTH;
  localparam int unsigned LW  = LGDMALENGTH;

  sched_state_t   state_q, state_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic           sticky_q, sticky_d;

  logic [NCH-1:0] ack_d, done_d, cherr_d;
  logic           busy_d, dreq_d, dabort_d;
  logic [CHW-1:0] active_d;
  logic [AW-1:0]  src_d, dst_d, sel_src, sel_dst;
  logic [LW-1:0]  len_d, sel_len;

  logic [CHW-1:0] gnt_idx;
  logic           gnt_vld;
  logic           tmo_hit_c;

  zaxdma_rrarb #(.NCH(NCH)) u_rrarb (
    .req (i_ch_req & ~i_ch_abort),
    .ptr (rr_q),
    .gnt (gnt_idx),
    .vld (gnt_vld)
  );

  // Descriptor of the channel the arbiter is currently pointing at
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (gnt_idx == CHW'(c)) begin
        sel_src = i_ch_src[field_lsb(c, AW) +: AW];
        sel_dst = i_ch_dst[field_lsb(c, AW) +: AW];
        sel_len = i_ch_len[field_lsb(c, LW) +: LW];
      end
    end
  end

`ifdef ZAXDMA_SCHED_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_ISSUE)
      tmo_cnt_d = '0;
    else if (state_q == S_RUN)
      tmo_cnt_d = tmo_cnt_q + LGTIMEOUT'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tmo_cnt_q <= '0;
    else            tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit_c = (state_q == S_RUN) && (tmo_cnt_d == '1) && i_dma_busy;
`else
  logic unused_tmo;
  assign unused_tmo = (LGTIMEOUT == 0);
  assign tmo_hit_c  = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sticky_d = sticky_q;
    ack_d    = '0;
    done_d   = '0;
    cherr_d  = '0;
    dreq_d   = 1'b0;
    dabort_d = 1'b0;
    active_d = o_active_ch;
    src_d    = o_src_addr;
    dst_d    = o_dst_addr;
    len_d    = o_length;

    unique case (state_q)
      S_IDLE: begin
        // A busy engine in IDLE is a fault; hold off new work until it clears
        if (gnt_vld && !i_dma_busy) begin
          ack_d[gnt_idx] = 1'b1;
          active_d       = gnt_idx;
          src_d          = sel_src;
          dst_d          = sel_dst;
          len_d          = sel_len;
          state_d        = (sel_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // First cycle raises the request, second lets the engine's busy register
        if (!o_dma_request) dreq_d  = 1'b1;
        else                state_d = S_RUN;
      end
      S_RUN: begin
        sticky_d = sticky_q | i_dma_err;
        if (!i_dma_busy) begin
          done_d[o_active_ch]  = 1'b1;
          cherr_d[o_active_ch] = sticky_d;
          state_d              = S_DONE;
        end else if (i_ch_abort[o_active_ch] || tmo_hit_c) begin
          dabort_d = 1'b1;
          sticky_d = 1'b1;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        sticky_d = sticky_q | i_dma_err;
        if (!i_dma_busy) begin
          done_d[o_active_ch]  = 1'b1;
          cherr_d[o_active_ch] = sticky_d;
          state_d              = S_DONE;
        end
      end
      S_DONE: begin
        // Zero-length grants arrive here without a done pulse yet
        if (o_ch_done == '0) begin
          done_d[o_active_ch]  = 1'b1;
          cherr_d[o_active_ch] = sticky_q;
        end else begin
          rr_d     = (o_active_ch == CHW'(NCH - 1)) ? '0 : o_active_ch + CHW'(1);
          sticky_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      sticky_q      <= 1'b0;
      o_ch_ack      <= '0;
      o_ch_done     <= '0;
      o_ch_err      <= '0;
      o_busy        <= 1'b0;
      o_active_ch   <= '0;
      o_dma_request <= 1'b0;
      o_dma_abort   <= 1'b0;
      o_src_addr    <= '0;
      o_dst_addr    <= '0;
      o_length      <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      sticky_q      <= sticky_d;
      o_ch_ack      <= ack_d;
      o_ch_done     <= done_d;
      o_ch_err      <= cherr_d;
      o_busy        <= busy_d;
      o_active_ch   <= active_d;
      o_dma_request <= dreq_d;
      o_dma_abort   <= dabort_d;
      o_src_addr    <= src_d;
      o_dst_addr    <= dst_d;
      o_length      <= len_d;
    end
  end

endmodule
